banner_ctrl: RTL and testbench

- Sequences the title/status text banners (GALAGA, PRESS ENTER, BOSS, GAME OVER, YOU WIN) over the game lifecycle.
- Drives the row address of each banner ROM from the VGA draw coordinates and selects the active banner's bit.
- Produces a registered per-pixel "banner on" flag plus a banner id for the colour mapper.
- Sits between the game-logic event pulses, the five banner ROMs and the colour mapper.

---
 rtl/banner_pkg.sv | 49 ++++
 rtl/banner_window.sv | 48 ++++
 rtl/banner_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_banner_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banner_pkg
// Description : Shared types and geometry for the banner sequencer.
//               state_t     - game lifecycle states
//               banner_id_t - banner identifiers for the colour mapper
//               Banner widths/heights, screen centre and pixel scale.
// Config      : BANNER_SCALE2_EN - when defined every ROM pixel is drawn
//               2x2 (SCALE = 2); otherwise 1x.
// Revision    : 1.0 - initial release
// ============================================================================
package banner_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    PLAY      = 3'd1,
    BOSS_SHOW = 3'd2,
    GAMEOVER  = 3'd3,
    WIN       = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ID_NONE     = 3'd0,
    ID_GALAGA   = 3'd1,
    ID_PRESS    = 3'd2,
    ID_BOSS     = 3'd3,
    ID_GAMEOVER = 3'd4,
    ID_WIN      = 3'd5
  } banner_id_t;

  localparam int SCREEN_CX  = 320;

  localparam int GALAGA_W   = 96;
  localparam int GAMEOVER_W = 128;
  localparam int WIN_W      = 112;
  localparam int BOSS_W     = 64;
  localparam int MAIN_H     = 16;

  localparam int PRESS_W    = 55;
  localparam int PRESS_H    = 5;

`ifdef BANNER_SCALE2_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

endpackage
`default_nettype wire

// File: rtl/banner_window.sv
`default_nettype none
// ============================================================================
// Module      : banner_window
// Description : Hit test of the draw coordinate against one banner window
//               and the ROM row/column of the pixel inside it.
// Ports       : draw_x, draw_y - current pixel (10 bit)
//               ox, oy         - window origin (11 bit)
//               w, h           - window size on screen (already scaled)
//               hit            - pixel lies inside the window
//               row, col       - ROM row / column of the pixel
// Config      : BANNER_SCALE2_EN - row/col are the screen offsets halved.
// Revision    : 1.0 - initial release
// ============================================================================
module banner_window #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 7
) (
  input  logic [9:0]          draw_x,
  input  logic [9:0]          draw_y,
  input  logic [10:0]         ox,
  input  logic [10:0]         oy,
  input  logic [10:0]         w,
  input  logic [10:0]         h,
  output logic                hit,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col
);

  // 11-bit signed offsets: coordinates left of / above the origin go negative
  logic signed [10:0] dx;
  logic signed [10:0] dy;

  assign dx = $signed({1'b0, draw_x} - ox);
  assign dy = $signed({1'b0, draw_y} - oy);

  assign hit = (dx >= 11'sd0) && (dx < $signed(w)) &&
               (dy >= 11'sd0) && (dy < $signed(h));

`ifdef BANNER_SCALE2_EN
  assign row = dy[ROW_BITS:1];
  assign col = dx[COL_BITS:1];
`else
  assign row = dy[ROW_BITS-1:0];
  assign col = dx[COL_BITS-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/banner_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : banner_ctrl
// Description : Sequences the GALAGA / PRESS ENTER / BOSS / GAME OVER /
//               YOU WIN banners over the game lifecycle, addresses the
//               banner ROMs from the draw coordinates and produces a
//               registered per-pixel lit flag and banner id.
// Ports       : Clk, Reset (sync, active high)
//               frame_tick, enter_key, boss_level, player_dead, all_cleared
//               DrawX, DrawY           - current pixel
//               main_addr, press_addr  - ROM row addresses (combinational)
//               *_data                 - ROM rows
//               pixel_on, pixel_id     - registered pixel result
//               game_active, state_out - status
// Config      : BANNER_SCALE2_EN - draw every ROM pixel 2x2.
// Revision    : 1.0 - initial release
// ============================================================================
module banner_ctrl
  import banner_pkg::*;
#(
  parameter int HOLD_FRAMES = 180,
  parameter int BLINK_LOG2  = 5,
  parameter int BANNER_Y    = 232,
  parameter int PRESS_Y     = 256
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_tick,
  input  logic         enter_key,
  input  logic         boss_level,
  input  logic         player_dead,
  input  logic         all_cleared,
  input  logic [9:0]   DrawX,
  input  logic [9:0]   DrawY,
  output logic [3:0]   main_addr,
  output logic [2:0]   press_addr,
  input  logic [95:0]  galaga_data,
  input  logic [127:0] gameover_data,
  input  logic [111:0] win_data,
  input  logic [63:0]  boss_data,
  input  logic [54:0]  press_data,
  output logic         pixel_on,
  output logic [2:0]   pixel_id,
  output logic         game_active,
  output logic [2:0]   state_out
);

  localparam logic [15:0] HOLD_INIT  = 16'(HOLD_FRAMES);
  localparam logic [10:0] MAIN_H_S   = 11'(MAIN_H * SCALE);
  localparam logic [10:0] PRESS_W_S  = 11'(PRESS_W * SCALE);
  localparam logic [10:0] PRESS_H_S  = 11'(PRESS_H * SCALE);
  localparam logic [10:0] PRESS_OX   = 11'(SCREEN_CX - (PRESS_W * SCALE) / 2);
  localparam logic [10:0] CX         = 11'(SCREEN_CX);

  state_t      state;
  logic [15:0] hold_cnt;
  logic [7:0]  blink_cnt;
  logic        enter_q;

  logic hold_done;
  logic blink_vis;
  logic enter_rise;

  assign hold_done  = (hold_cnt == 16'd0);
  assign blink_vis  = ~blink_cnt[BLINK_LOG2];
  // Edge-triggered ENTER so a key held across a state change never retriggers
  assign enter_rise = enter_key & ~enter_q;

  // --------------------------------------------------------------------------
  // Lifecycle FSM with hold and blink counters
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= TITLE;
      hold_cnt  <= 16'd0;
      blink_cnt <= 8'd0;
      enter_q   <= 1'b0;
    end else begin
      enter_q <= enter_key;
      if (frame_tick)
        blink_cnt <= blink_cnt + 8'd1;
      if (frame_tick && !hold_done)
        hold_cnt <= hold_cnt - 16'd1;

      // Loads below are written after the decrement so they take precedence
      case (state)
        TITLE: begin
          if (enter_rise)
            state <= PLAY;
        end
        PLAY: begin
          if (player_dead) begin
            state    <= GAMEOVER;
            hold_cnt <= HOLD_INIT;
          end else if (all_cleared) begin
            state    <= WIN;
            hold_cnt <= HOLD_INIT;
          end else if (boss_level) begin
            state    <= BOSS_SHOW;
            hold_cnt <= HOLD_INIT;
          end
        end
        BOSS_SHOW: begin
          if (player_dead) begin
            state    <= GAMEOVER;
            hold_cnt <= HOLD_INIT;
          end else if (all_cleared) begin
            state    <= WIN;
            hold_cnt <= HOLD_INIT;
          end else if (hold_done) begin
            state <= PLAY;
          end
        end
        GAMEOVER, WIN: begin
          if (enter_rise && hold_done)
            state <= TITLE;
        end
        default: state <= TITLE;
      endcase
    end
  end

  assign game_active = (state == PLAY) || (state == BOSS_SHOW);
  assign state_out   = state;

  // --------------------------------------------------------------------------
  // Banner selection and windows
  // --------------------------------------------------------------------------
  banner_id_t  main_id;
  logic [10:0] main_w_s;
  logic [10:0] main_ox;
  logic        main_hit;
  logic [3:0]  main_row;
  logic [6:0]  main_col;
  logic        main_bit;

  logic        press_hit;
  logic [2:0]  press_row;
  logic [5:0]  press_col;
  logic        press_vis;

  logic [6:0]  gal_idx;
  logic [6:0]  go_idx;
  logic [6:0]  win_idx;
  logic [5:0]  boss_idx;
  logic [5:0]  press_idx;

  // Column 0 is the leftmost pixel, stored in the MSB of each ROM row
  assign gal_idx   = 7'(GALAGA_W - 1)   - main_col;
  assign go_idx    = 7'(GAMEOVER_W - 1) - main_col;
  assign win_idx   = 7'(WIN_W - 1)      - main_col;
  assign boss_idx  = 6'(BOSS_W - 1)     - main_col[5:0];
  assign press_idx = 6'(PRESS_W - 1)    - press_col;

  always_comb begin
    main_id  = ID_NONE;
    main_w_s = 11'd0;
    main_bit = 1'b0;
    case (state)
      TITLE: begin
        main_id  = ID_GALAGA;
        main_w_s = 11'(GALAGA_W * SCALE);
        main_bit = galaga_data[gal_idx];
      end
      BOSS_SHOW: begin
        main_id  = ID_BOSS;
        main_w_s = 11'(BOSS_W * SCALE);
        main_bit = boss_data[boss_idx];
      end
      GAMEOVER: begin
        main_id  = ID_GAMEOVER;
        main_w_s = 11'(GAMEOVER_W * SCALE);
        main_bit = gameover_data[go_idx];
      end
      WIN: begin
        main_id  = ID_WIN;
        main_w_s = 11'(WIN_W * SCALE);
        main_bit = win_data[win_idx];
      end
      default: ;
    endcase
  end

  // Centre the main banner horizontally
  assign main_ox = CX - (main_w_s >> 1);

  // PRESS ENTER blinks on TITLE, and on GAMEOVER/WIN only once the hold ends
  assign press_vis = blink_vis &&
                     ((state == TITLE) ||
                      (((state == GAMEOVER) || (state == WIN)) && hold_done));

  banner_window #(
    .ROW_BITS (4),
    .COL_BITS (7)
  ) u_main_win (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .ox     (main_ox),
    .oy     (11'(BANNER_Y)),
    .w      (main_w_s),
    .h      (MAIN_H_S),
    .hit    (main_hit),
    .row    (main_row),
    .col    (main_col)
  );

  banner_window #(
    .ROW_BITS (3),
    .COL_BITS (6)
  ) u_press_win (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .ox     (PRESS_OX),
    .oy     (11'(PRESS_Y)),
    .w      (PRESS_W_S),
    .h      (PRESS_H_S),
    .hit    (press_hit),
    .row    (press_row),
    .col    (press_col)
  );

  assign main_addr  = main_row;
  assign press_addr = press_row;

  // --------------------------------------------------------------------------
  // Registered pixel result; main banner wins where windows overlap
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_on <= 1'b0;
      pixel_id <= ID_NONE;
    end else if ((main_id != ID_NONE) && main_hit) begin
      pixel_on <= main_bit;
      pixel_id <= main_id;
    end else if (press_vis && press_hit) begin
      pixel_on <= press_data[press_idx];
      pixel_id <= ID_PRESS;
    end else begin
      pixel_on <= 1'b0;
      pixel_id <= ID_NONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_banner_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_banner_ctrl
// Description : Self-checking bench for banner_ctrl. Banner ROMs are random
//               tables; a frame/rule based reference model predicts state,
//               addresses and the registered pixel every cycle.
// Config      : BANNER_SCALE2_EN - bench geometry follows the same macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banner_ctrl;

`ifdef BANNER_SCALE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic         Clk = 1'b0;
  logic         Reset, frame_tick, enter_key, boss_level, player_dead, all_cleared;
  logic [9:0]   DrawX, DrawY;
  logic [3:0]   main_addr;
  logic [2:0]   press_addr;
  logic [95:0]  galaga_data;
  logic [127:0] gameover_data;
  logic [111:0] win_data;
  logic [63:0]  boss_data;
  logic [54:0]  press_data;
  logic         pixel_on;
  logic [2:0]   pixel_id;
  logic         game_active;
  logic [2:0]   state_out;

  logic [95:0]  rom_gal   [16];
  logic [127:0] rom_go    [16];
  logic [111:0] rom_win   [16];
  logic [63:0]  rom_boss  [16];
  logic [54:0]  rom_press [8];

  assign galaga_data   = rom_gal[main_addr];
  assign gameover_data = rom_go[main_addr];
  assign win_data      = rom_win[main_addr];
  assign boss_data     = rom_boss[main_addr];
  assign press_data    = rom_press[press_addr];

  always #5 Clk = ~Clk;

  banner_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .enter_key     (enter_key),
    .boss_level    (boss_level),
    .player_dead   (player_dead),
    .all_cleared   (all_cleared),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .main_addr     (main_addr),
    .press_addr    (press_addr),
    .galaga_data   (galaga_data),
    .gameover_data (gameover_data),
    .win_data      (win_data),
    .boss_data     (boss_data),
    .press_data    (press_data),
    .pixel_on      (pixel_on),
    .pixel_id      (pixel_id),
    .game_active   (game_active),
    .state_out     (state_out)
  );

  // Model state codes: 0 TITLE, 1 PLAY, 2 BOSS, 3 GAMEOVER, 4 WIN
  int checks = 0;
  int errors = 0;
  int m_state;
  int m_hold;       // frames still to wait before the next action
  int m_frames;     // frames seen since reset, modulo 256
  bit m_prev_enter;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_box(input int x, input int y, input int ox, input int oy,
                                input int w, input int h);
    return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
  endfunction

  // What the pixel at (x,y) looks like for the given lifecycle situation
  function automatic void model_pixel(input int st, input int hold, input int frames,
                                      input int x, input int y,
                                      output int on, output int id);
    int w, mid, ox, c, r;
    bit vis, main_in;
    on = 0; id = 0; w = 0; mid = 0;
    case (st)
      0: begin w = 96;  mid = 1; end
      2: begin w = 64;  mid = 3; end
      3: begin w = 128; mid = 4; end
      4: begin w = 112; mid = 5; end
      default: begin w = 0; mid = 0; end
    endcase
    vis = (((frames % 256) / 32) % 2) == 0;
    ox = 320 - (w * S) / 2;
    main_in = (mid != 0) && in_box(x, y, ox, 232, w * S, 16 * S);
    if (main_in) begin
      c = (x - ox) / S;
      r = (y - 232) / S;
      id = mid;
      case (mid)
        1: on = rom_gal[r][95 - c];
        3: on = rom_boss[r][63 - c];
        4: on = rom_go[r][127 - c];
        default: on = rom_win[r][111 - c];
      endcase
    end else if (vis && (st == 0 || ((st == 3 || st == 4) && hold == 0))) begin
      ox = 320 - (55 * S) / 2;
      if (in_box(x, y, ox, 256, 55 * S, 5 * S)) begin
        c = (x - ox) / S;
        r = (y - 256) / S;
        id = 2;
        on = rom_press[r][54 - c];
      end
    end
  endfunction

  // One clock cycle; x/y < 0 picks a random coordinate near the banners
  task automatic step(input bit tk, input bit en, input bit bs, input bit dd,
                      input bit cl, input int x, input int y);
    int xx, yy, on_e, id_e, ns;
    bit rise, hd, load;
    xx = (x < 0) ? int'($urandom_range(250, 400)) : x;
    yy = (y < 0) ? int'($urandom_range(225, 275)) : y;
    frame_tick = tk; enter_key = en; boss_level = bs;
    player_dead = dd; all_cleared = cl;
    DrawX = 10'(xx); DrawY = 10'(yy);
    #1;
    check("main_addr", 32'(main_addr), 32'(((yy - 232) >>> (S - 1)) & 15));
    check("press_addr", 32'(press_addr), 32'(((yy - 256) >>> (S - 1)) & 7));
    model_pixel(m_state, m_hold, m_frames, xx, yy, on_e, id_e);

    rise = en && !m_prev_enter;
    hd   = (m_hold == 0);
    ns   = m_state;
    load = 0;
    case (m_state)
      0: if (rise) ns = 1;
      1: begin
        if (dd)      begin ns = 3; load = 1; end
        else if (cl) begin ns = 4; load = 1; end
        else if (bs) begin ns = 2; load = 1; end
      end
      2: begin
        if (dd)      begin ns = 3; load = 1; end
        else if (cl) begin ns = 4; load = 1; end
        else if (hd) ns = 1;
      end
      default: if (rise && hd) ns = 0;
    endcase
    if (load) m_hold = 180;
    else if (tk && m_hold > 0) m_hold--;
    if (tk) m_frames = (m_frames + 1) % 256;
    m_prev_enter = en;
    m_state = ns;

    @(posedge Clk); #1;
    check("state_out", 32'(state_out), 32'(m_state));
    check("game_active", 32'(game_active), 32'((m_state == 1 || m_state == 2) ? 1 : 0));
    check("pixel_on", 32'(pixel_on), 32'(on_e));
    check("pixel_id", 32'(pixel_id), 32'(id_e));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    frame_tick = 0; enter_key = 0; boss_level = 0; player_dead = 0; all_cleared = 0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_state = 0; m_hold = 0; m_frames = 0; m_prev_enter = 0;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_pixel_on", 32'(pixel_on), 32'd0);
    check("rst_pixel_id", 32'(pixel_id), 32'd0);
    check("rst_game_active", 32'(game_active), 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, -1, -1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_gal[i]  = 96'({$urandom, $urandom, $urandom});
      rom_go[i]   = {$urandom, $urandom, $urandom, $urandom};
      rom_win[i]  = 112'({$urandom, $urandom, $urandom, $urandom});
      rom_boss[i] = {$urandom, $urandom};
    end
    for (int i = 0; i < 8; i++) rom_press[i] = 55'({$urandom, $urandom});
    rom_gal[2][94]  = 1'b1;   // GALAGA pixel at (273,234)
    rom_press[0][54] = 1'b1;  // PRESS ENTER pixel at (293,256)

    Reset = 1'b1;
    DrawX = 10'd0; DrawY = 10'd0;
    do_reset();

    // TITLE: GALAGA window edge
    step(0, 0, 0, 0, 0, 273, 234);
    step(0, 0, 0, 0, 0, 272, 234);
    step(0, 0, 0, 0, 0, 273 + 96 * S - 1, 234);
    step(0, 0, 0, 0, 0, 273 + 96 * S - 1, 232 + 16 * S);

    // PRESS ENTER blink: visible, hidden after 32 frames, back after 64
    step(0, 0, 0, 0, 0, 293, 256);
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0, 293, 256);
    step(0, 0, 0, 0, 0, 293, 256);
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0, 293, 256);
    step(0, 0, 0, 0, 0, 293, 256);

    // Random draw coordinates on TITLE
    for (int i = 0; i < 200; i++) step(($urandom_range(0, 3) == 0), 0, 0, 0, 0, -1, -1);

    // TITLE -> PLAY, held ENTER does nothing more
    step(0, 1, 0, 0, 0, -1, -1);
    check("enter_to_play", 32'(state_out), 32'd1);
    step(0, 1, 0, 0, 0, -1, -1);
    step(0, 0, 0, 0, 0, -1, -1);

    // PLAY -> BOSS_SHOW, hold 180 frames, back to PLAY
    step(0, 0, 1, 0, 0, -1, -1);
    check("boss_enter", 32'(state_out), 32'd2);
    ticks(179);
    check("boss_still", 32'(state_out), 32'd2);
    ticks(1);
    step(0, 0, 0, 0, 0, -1, -1);
    check("boss_to_play", 32'(state_out), 32'd1);

    // Coincident dead + cleared: dead wins
    step(0, 0, 0, 1, 1, -1, -1);
    check("dead_priority", 32'(state_out), 32'd3);

    // ENTER during hold ignored, accepted after hold
    ticks(100);
    step(0, 1, 0, 0, 0, -1, -1);
    step(0, 0, 0, 0, 0, -1, -1);
    check("go_enter_ignored", 32'(state_out), 32'd3);
    ticks(80);
    for (int i = 0; i < 80; i++) step(($urandom_range(0, 3) == 0), 0, 0, 0, 0, -1, -1);
    step(0, 1, 0, 0, 0, -1, -1);
    check("go_to_title", 32'(state_out), 32'd0);
    step(0, 0, 0, 0, 0, -1, -1);

    // BOSS preempted by player_dead at tick 10, hold reloaded
    step(0, 1, 0, 0, 0, -1, -1);
    step(0, 0, 1, 0, 0, -1, -1);
    ticks(10);
    step(0, 0, 0, 1, 0, -1, -1);
    check("boss_preempt", 32'(state_out), 32'd3);
    ticks(179);
    step(0, 1, 0, 0, 0, -1, -1);
    step(0, 0, 0, 0, 0, -1, -1);
    check("reload_hold", 32'(state_out), 32'd3);
    ticks(1);
    step(0, 1, 0, 0, 0, -1, -1);
    check("reload_to_title", 32'(state_out), 32'd0);
    step(0, 0, 0, 0, 0, -1, -1);

    // PLAY -> WIN, YOU WIN banner, then back to TITLE
    step(0, 1, 0, 0, 0, -1, -1);
    step(0, 0, 1, 0, 1, -1, -1);
    check("cleared_to_win", 32'(state_out), 32'd4);
    for (int i = 0; i < 400; i++) step(($urandom_range(0, 1) == 0), 0, 0, 0, 0, -1, -1);
    step(0, 1, 0, 0, 0, -1, -1);
    check("win_to_title", 32'(state_out), 32'd0);

    // Random event soup
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) == 0),
           ($urandom_range(0, 150) == 0), -1, -1);

    // Reset mid-game
    step(0, 0, 0, 0, 0, -1, -1);
    step(0, 1, 0, 0, 0, -1, -1);
    step(0, 0, 0, 0, 0, -1, -1);
    do_reset();
    step(0, 0, 0, 0, 0, 273, 234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
